// File: rtl/pc_pkg.sv
// Shared types and widths for the PC / instruction-fetch stage.
package pc_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] DEFAULT_INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {BOOT, RUN, HOLD} fetch_state_t;
endpackage

// File: rtl/pc_next_mux.sv
// Adder operand selection and next-PC choice on an accepted request; purely combinational.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_pc,
  input  logic [PC_W-1:0] br_offset,
  input  logic [PC_W-1:0] pc,
  input  logic            redir_pend,
  input  logic [PC_W-1:0] redir_pc,
  input  logic [PC_W-1:0] pc_add_sum,
  output logic [PC_W-1:0] add_a,
  output logic [PC_W-1:0] add_b,
  output logic [PC_W-1:0] hs_next_pc
);
  assign add_a = br_taken ? br_pc : pc;
  assign add_b = br_taken ? br_offset : INSTR_BYTES;

  // A same-cycle branch is newer than any buffered redirect, so it wins.
  assign hs_next_pc = (redir_pend && !br_taken) ? redir_pc : pc_add_sum;
endmodule

// File: rtl/pc_fetch.sv
// PC register and fetch request stage: one request per accepted cycle, fetch_valid 1 cycle after handshake.
// Backpressure: an unaccepted request is held with a stable address; redirects arriving meanwhile are buffered.
module pc_fetch
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [PC_W-1:0] INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_pc,
  input  logic [PC_W-1:0] br_offset,
  output logic [PC_W-1:0] pc_add_a,
  output logic [PC_W-1:0] pc_add_b,
  input  logic [PC_W-1:0] pc_add_sum,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_addr,
  output logic            fetch_valid,
  output logic [PC_W-1:0] fetch_pc
);
  fetch_state_t    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] redir_pc_q;
  logic            redir_pend_q;
  logic            fetch_valid_q;
  logic [PC_W-1:0] fetch_pc_q;
  logic [PC_W-1:0] hs_next_pc;
  logic            hs;

  pc_next_mux #(.INSTR_BYTES(INSTR_BYTES)) u_next_mux (
    .br_taken   (br_taken),
    .br_pc      (br_pc),
    .br_offset  (br_offset),
    .pc         (pc_q),
    .redir_pend (redir_pend_q),
    .redir_pc   (redir_pc_q),
    .pc_add_sum (pc_add_sum),
    .add_a      (pc_add_a),
    .add_b      (pc_add_b),
    .hs_next_pc (hs_next_pc)
  );

  // Once raised, a request stays up in HOLD even if stall asserts.
  assign imem_req_valid = (state_q == HOLD) || ((state_q == RUN) && !stall);
  assign imem_addr      = pc_q;
  assign hs             = imem_req_valid && imem_req_ready;
  assign fetch_valid    = fetch_valid_q;
  assign fetch_pc       = fetch_pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      redir_pc_q    <= '0;
      redir_pend_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
    end else begin
      fetch_valid_q <= 1'b0;
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          if (br_taken) pc_q <= pc_add_sum;
        end
        RUN, HOLD: begin
          if (hs) begin
            state_q      <= RUN;
            pc_q         <= hs_next_pc;
            redir_pend_q <= 1'b0;
            // Any redirect tied to this handshake squashes the fetched word.
            if (!br_taken && !redir_pend_q) begin
              fetch_valid_q <= 1'b1;
              fetch_pc_q    <= pc_q;
            end
          end else if (state_q == HOLD) begin
            if (br_taken) begin
              redir_pc_q   <= pc_add_sum;
              redir_pend_q <= 1'b1;
            end
          end else begin
            if (imem_req_valid) state_q <= HOLD;
            if (br_taken) pc_q <= pc_add_sum;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter register and instruction-fetch request stage. Holds the architectural PC, drives the operands of the shared 32-bit PC adder, consumes its sum as the next PC, and issues one instruction-memory request per accepted cycle through a valid/ready handshake. Supports stall and branch redirect, with a one-entry pending-redirect buffer while a request is outstanding. Sits between branch resolution and instruction memory, upstream of decode.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `INSTR_BYTES`, default 4: sequential increment, in bytes.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `stall`  in  1: hold PC, suppress new requests.
- `br_taken`  in  1: single-cycle redirect strobe.
- `br_pc`  in  32: PC of the branching instruction.
- `br_offset`  in  32: signed byte offset added to `br_pc`.
- `pc_add_a`  out  32: adder operand A (`current_pc`).
- `pc_add_b`  out  32: adder operand B (`in`).
- `pc_add_sum`  in  32: adder result (`out`), combinational.
- `imem_req_valid`  out  1: fetch request valid.
- `imem_req_ready`  in  1: memory accepts request.
- `imem_addr`  out  32: fetch byte address.
- `fetch_valid`  out  1: registered, one-cycle pulse per delivered fetch.
- `fetch_pc`  out  32: PC of the delivered fetch.

## Operation
- Adder muxing: `br_taken`=1 -> A=`br_pc`, B=`br_offset`; else A=`pc`, B=`INSTR_BYTES`. Sum wraps mod 2^32; no overflow flag.
- States: BOOT, RUN, HOLD.
- BOOT: entered on reset; `imem_req_valid`=0. Next cycle -> RUN.
- RUN: `imem_req_valid`=!`stall`, `imem_addr`=`pc`.
  - Handshake (valid & ready): `pc` <= `pc_add_sum`; next cycle `fetch_valid`=1, `fetch_pc`=old `pc`.
  - valid & !ready -> HOLD, `pc` unchanged.
  - `stall`=1: `pc` unchanged, no request, stay RUN.
- HOLD: `imem_req_valid`=1 and `imem_addr` stable regardless of `stall` (request, once raised, is not withdrawn). On ready -> RUN, `pc` advances as above.
- Redirect:
  - BOOT or RUN without handshake (incl. stall): `pc` <= target immediately.
  - RUN with same-cycle handshake: `pc` <= target; the accepted request is squashed (`fetch_valid`=0 next cycle).
  - HOLD: target -> `redir_pc`, `redir_pend`=1; address unchanged. On the handshake: `pc` <= `redir_pc`, `redir_pend` cleared, request squashed.
  - Second `br_taken` while pending: newest target overwrites `redir_pc`.
  - `br_taken` in the HOLD handshake cycle: the new target wins over `redir_pc`.
- Reset mid-operation (any state): outstanding request abandoned, pending redirect dropped.

## Timing
- Reset values: `pc`=`RESET_PC`, state BOOT, `imem_req_valid`=0, `fetch_valid`=0, `fetch_pc`=0, `redir_pend`=0, `redir_pc`=0.
- Reset high in cycle N -> BOOT in N+1 -> first request (addr `RESET_PC`) in N+2.
- Handshake-to-`fetch_valid` latency: 1 cycle.
- Throughput: 1 request per cycle with `imem_req_ready` held high.
- `imem_addr`, `imem_req_valid` are combinational from registered state and `stall` only; they never depend on `imem_req_ready`.

## Structure
- Package `pc_pkg`: `fetch_state_t` enum {BOOT, RUN, HOLD}, `PC_W`=32, default `INSTR_BYTES`.
- Single module. Adder stays external behind the `pc_add_*` ports. Optional sub-module `pc_next_mux` for operand and next-PC selection.

## Test plan
- Reset, ready=1: requests 0x0, 0x4, 0x8 on consecutive cycles; `fetch_pc` follows one cycle later; no request in the BOOT cycle.
- `stall` for 3 cycles at pc=0x10: valid low, pc stays 0x10; resumes with 0x10 then 0x14.
- ready low for 2 cycles at 0x20: addr held at 0x20 and valid held high even with `stall`=1; after accept, next request is 0x24.
- `br_taken`, `br_pc`=0x40, `br_offset`=-8, coincident with handshake at 0x8: that fetch is squashed; next request is 0x38.
- In HOLD at 0x30, redirects to 0x100 then 0x200: addr stays 0x30 until ready, fetch squashed, next request is 0x200.
- `pc`=0xFFFF_FFFC, ready=1: next request is 0x0 (wrap). `reset` asserted in HOLD: valid drops next cycle and restarts at `RESET_PC`.
